quad_enc_input_decoder: RTL and testbench
=========================================

Name: quad_enc_input_decoder

Overview:
- Receive side of the encoder/Hall digital-signal path: decodes an incoming quadrature encoder channel (A, B, Index) received on a differential digital input pair into a signed-agnostic position count.
- Each input is synchronized and glitch-filtered, then decoded at 4x resolution. Index position is latched, and illegal quadrature transitions are flagged.
- Sits between the differential input receivers and the host register interface. Its output is used to loop-back verify the encoder signals driven on the digital outputs.

Parameters:
- CNT_W, 16, width of position and index_position counters
- FILT_LEN, 4, consecutive stable clocks required before a filtered input changes (range 2..15)

Ports:
- xclk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = counting active; 0 = position frozen, filters keep tracking
- enc_a_in  input  1  raw encoder A (async to xclk)
- enc_b_in  input  1  raw encoder B (async)
- enc_i_in  input  1  raw encoder Index (async)
- clear_count  input  1  single-cycle pulse: position <= 0
- index_clear_en  input  1  1 = Index rising edge zeroes position
- error_clear  input  1  single-cycle pulse: clears quad_error
- position  output  CNT_W  current 4x count, modulo 2^CNT_W
- index_position  output  CNT_W  position value captured at last Index rising edge
- index_seen  output  1  sticky; set on first Index rising edge, cleared by reset or clear_count
- direction  output  1  1 = last valid step was +1, 0 = last was -1
- quad_error  output  1  sticky illegal-transition flag

Behaviour:
- Reset values: all outputs 0. Filtered A/B/I = 0. Filter counters = 0. Previous AB state = 00.
- Synchronizer: 2 flip-flops per input. The raw value appears at sync output on the 2nd clock edge after it is sampled.
- Filter:
  - Counter increments while sync output differs from the filtered value. It resets to 0 when they are equal.
  - When the counter reaches FILT_LEN-1 and they still differ, filtered value <= sync output and counter <= 0.
  - Pulses shorter than FILT_LEN clocks are fully rejected.
- Decode is registered; it compares filtered {A,B} with previous {A,B} each clock.
  - +1 sequence: 00->01->11->10->00. Reverse order is -1.
  - No change: hold.
  - Both bits changed (00<->11, 01<->10): quad_error <= 1. No count change; direction unchanged.
  - Previous AB updates every clock, even when enable = 0, so re-enable produces no spurious step.
- Latency: a clean edge on enc_a_in/enc_b_in, stable thereafter, changes position exactly FILT_LEN+3 clocks after the first sampling edge.
- Counter arithmetic is modulo 2^CNT_W. 0 - 1 = all ones; all ones + 1 = 0. No saturation and no flag.
- Index:
  - A rising edge of filtered I latches index_position <= next position value (including any same-cycle step) and sets index_seen.
  - It latches regardless of enable.
- Per-cycle priority for position: reset > clear_count > (Index rise & index_clear_en & enable -> 0) > (enable & valid step -> ±1) > hold.
- clear_count also clears index_seen. It does not clear index_position, quad_error, or direction.
- quad_error: error_clear clears it. If an illegal transition and error_clear occur in the same cycle, quad_error remains 1 (set wins).
- Reset mid-sequence: the filters restart from 0. If the inputs are high when reset releases, the filters need FILT_LEN+2 clocks to acquire the input levels. The resulting first AB change is decoded normally; a 00->11 acquisition sets quad_error. Software clears it with error_clear after reset.

Decomposition:
- Shared package holds:
  - AB state constants (QUAD_S00, QUAD_S01, QUAD_S11, QUAD_S10)
  - Direction codes (DIR_FWD = 1, DIR_REV = 0)
  - Step codes (STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR)
- One natural sub-module, din_sync_filter: 2-FF synchronizer plus stability filter parameterized by FILT_LEN. It is instantiated three times (A, B, I) and is reusable for Hall and single-ended digital inputs.

Test Plan:
- Forward: reset, enable = 1, drive 8 full forward quadrature cycles (AB period 40 clocks) -> position = 32, direction = 1, quad_error = 0; first step observed exactly 7 clocks after the first A edge (FILT_LEN = 4).
- Reverse wrap: from position = 0, drive 3 reverse steps -> position = 16'hFFFD, direction = 0; then 3 forward steps -> 16'h0000.
- Glitch: 3-clock high pulse on enc_a_in -> position unchanged; 4-clock stable high -> filtered A changes, position +1.
- Illegal transition: AB 00 -> 11 simultaneously -> quad_error = 1, position unchanged. error_clear pulse -> 0. Repeat with error_clear coincident with the illegal step -> quad_error stays 1.
- Index: at position = 100, Index rises with index_clear_en = 0 -> index_position = 100, index_seen = 1, position continues counting. Repeat with index_clear_en = 1 -> position = 0. clear_count pulsed in the same cycle -> position = 0 and index_seen = 0.
- Enable/reset: enable = 0 during 5 forward steps -> position frozen; re-enable with AB static -> no step. Assert reset mid-count -> all outputs 0 on the next clock.

Source files
------------

// File: rtl/quad_enc_input_decoder_pkg.sv
// ---------------------------------------------------------------------------
// quad_enc_input_decoder_pkg
// Shared definitions for the quadrature encoder receive path. It holds the
// quadrature AB state codes, the direction codes, the per-clock step
// classification used by the decoder, and the helper functions that classify
// an AB transition.
// ---------------------------------------------------------------------------
package quad_enc_input_decoder_pkg;

   // Filtered {A,B} levels, listed in forward (+1) order.
   localparam logic [1:0] QUAD_S00 = 2'b00;
   localparam logic [1:0] QUAD_S01 = 2'b01;
   localparam logic [1:0] QUAD_S11 = 2'b11;
   localparam logic [1:0] QUAD_S10 = 2'b10;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   // This width is enough for the largest supported filter length (15).
   localparam int FILT_CNT_W = 4;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_INC  = 2'd1,
      STEP_DEC  = 2'd2,
      STEP_ERR  = 2'd3
   } step_t;

   // Returns the AB state that one forward step leads to.
   function automatic logic [1:0] fwd_next(input logic [1:0] ab);
      logic [1:0] nxt;
      case (ab)
         QUAD_S00: nxt = QUAD_S01;
         QUAD_S01: nxt = QUAD_S11;
         QUAD_S11: nxt = QUAD_S10;
         default:  nxt = QUAD_S00;
      endcase
      return nxt;
   endfunction

   // Classifies one clock of AB history. When neither state is the forward
   // neighbour of the other, both bits have changed, and that is illegal.
   function automatic step_t quad_step(input logic [1:0] prev_ab,
                                       input logic [1:0] curr_ab);
      step_t s;
      if (curr_ab == prev_ab)
         s = STEP_NONE;
      else if (curr_ab == fwd_next(prev_ab))
         s = STEP_INC;
      else if (prev_ab == fwd_next(curr_ab))
         s = STEP_DEC;
      else
         s = STEP_ERR;
      return s;
   endfunction

endpackage

// File: rtl/din_sync_filter.sv
// ---------------------------------------------------------------------------
// din_sync_filter
// This block takes one asynchronous digital input. It passes the input
// through a two-flop synchronizer and then a stability filter. The filtered
// output changes only after the synchronized level has differed from it for
// FILT_LEN consecutive clocks, so shorter pulses are rejected completely. The
// block is reusable for encoder, Hall and single-ended digital inputs.
//
// Ports:
//   xclk     - system clock, rising edge
//   reset    - synchronous active-high reset (clears synchronizer and filter)
//   raw      - asynchronous input level
//   filtered - synchronized, debounced level
// ---------------------------------------------------------------------------
module din_sync_filter
   import quad_enc_input_decoder_pkg::*;
#(
   parameter int FILT_LEN = 4
)
(
   input  logic xclk,
   input  logic reset,
   input  logic raw,
   output logic filtered
);

   localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

   logic                  sync_p0;
   logic                  sync_p1;
   logic [FILT_CNT_W-1:0] stable_cnt;

   // ---- synchronizer (p0, p1) -> filter ----
   always_ff @(posedge xclk) begin
      if (reset) begin
         sync_p0    <= 1'b0;
         sync_p1    <= 1'b0;
         stable_cnt <= '0;
         filtered   <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         // The counter measures how long the synchronized level has
         // disagreed with the output. Any return to agreement restarts it.
         if (sync_p1 != filtered) begin
            if (stable_cnt == CNT_LAST) begin
               filtered   <= sync_p1;
               stable_cnt <= '0;
            end else begin
               stable_cnt <= stable_cnt + 1'b1;
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/quad_enc_input_decoder.sv
// ---------------------------------------------------------------------------
// quad_enc_input_decoder
// This block decodes a received quadrature encoder channel (A, B, Index) into
// a 4x position count. Each input is synchronized and glitch-filtered. The
// block then registers the AB transition and applies it to the position
// counter. It latches the count at each Index rising edge and keeps a sticky
// flag for illegal transitions, where both bits change at once.
//
// Ports:
//   xclk           - system clock, rising edge
//   reset          - synchronous active-high reset
//   enable         - 1 = count; 0 = position frozen (filters keep tracking)
//   enc_a_in       - raw encoder A (async)
//   enc_b_in       - raw encoder B (async)
//   enc_i_in       - raw encoder Index (async)
//   clear_count    - pulse: zero position and index_seen
//   index_clear_en - Index rising edge zeroes position
//   error_clear    - pulse: clear quad_error
//   position       - 4x count, modulo 2^CNT_W
//   index_position - position captured at the last Index rising edge
//   index_seen     - sticky, set by Index rising edge
//   direction      - 1 = last valid step was +1, 0 = -1
//   quad_error     - sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_enc_input_decoder
   import quad_enc_input_decoder_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int FILT_LEN = 4
)
(
   input  logic             xclk,
   input  logic             reset,
   input  logic             enable,
   input  logic             enc_a_in,
   input  logic             enc_b_in,
   input  logic             enc_i_in,
   input  logic             clear_count,
   input  logic             index_clear_en,
   input  logic             error_clear,
   output logic [CNT_W-1:0] position,
   output logic [CNT_W-1:0] index_position,
   output logic             index_seen,
   output logic             direction,
   output logic             quad_error
);

   logic             filt_a;
   logic             filt_b;
   logic             filt_i;

   logic [1:0]       ab_prev_p0;
   logic             i_prev_p0;
   step_t            step_p0;
   logic             i_rise_p0;

   logic [CNT_W-1:0] pos_next;

   din_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
      .xclk     (xclk),
      .reset    (reset),
      .raw      (enc_a_in),
      .filtered (filt_a)
   );

   din_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
      .xclk     (xclk),
      .reset    (reset),
      .raw      (enc_b_in),
      .filtered (filt_b)
   );

   din_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_i (
      .xclk     (xclk),
      .reset    (reset),
      .raw      (enc_i_in),
      .filtered (filt_i)
   );

   // ---- decode stage p0: classify AB change, detect Index rise ----
   // The previous AB state is tracked even while counting is disabled. This
   // way, re-enabling cannot produce a step from a stale state.
   always_ff @(posedge xclk) begin
      if (reset) begin
         ab_prev_p0 <= QUAD_S00;
         i_prev_p0  <= 1'b0;
         step_p0    <= STEP_NONE;
         i_rise_p0  <= 1'b0;
      end else begin
         ab_prev_p0 <= {filt_a, filt_b};
         i_prev_p0  <= filt_i;
         step_p0    <= quad_step(ab_prev_p0, {filt_a, filt_b});
         i_rise_p0  <= filt_i & ~i_prev_p0;
      end
   end

   // Next count, by priority: clear, index zeroing, step, hold.
   always_comb begin
      pos_next = position;
      if (clear_count)
         pos_next = '0;
      else if (i_rise_p0 && index_clear_en && enable)
         pos_next = '0;
      else if (enable && (step_p0 == STEP_INC))
         pos_next = position + CNT_W'(1);
      else if (enable && (step_p0 == STEP_DEC))
         pos_next = position - CNT_W'(1);
   end

   // ---- count stage p1: position, index capture, flags ----
   always_ff @(posedge xclk) begin
      if (reset) begin
         position       <= '0;
         index_position <= '0;
         index_seen     <= 1'b0;
         direction      <= 1'b0;
         quad_error     <= 1'b0;
      end else begin
         position <= pos_next;
         // The capture takes the value position is about to hold, so a step
         // or a zeroing in the same cycle is included.
         if (i_rise_p0)
            index_position <= pos_next;
         if (clear_count)
            index_seen <= 1'b0;
         else if (i_rise_p0)
            index_seen <= 1'b1;
         if (enable && (step_p0 == STEP_INC))
            direction <= DIR_FWD;
         else if (enable && (step_p0 == STEP_DEC))
            direction <= DIR_REV;
         // When a new error arrives in the same cycle as a clear, the error
         // wins.
         if (step_p0 == STEP_ERR)
            quad_error <= 1'b1;
         else if (error_clear)
            quad_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_quad_enc_input_decoder.sv
module tb_quad_enc_input_decoder;
   localparam int CNT_W    = 16;
   localparam int FILT_LEN = 4;
   localparam int HW       = 8;

   logic             xclk = 1'b0;
   logic             reset;
   logic             enable;
   logic             enc_a_in;
   logic             enc_b_in;
   logic             enc_i_in;
   logic             clear_count;
   logic             index_clear_en;
   logic             error_clear;
   logic [CNT_W-1:0] position;
   logic [CNT_W-1:0] index_position;
   logic             index_seen;
   logic             direction;
   logic             quad_error;

   quad_enc_input_decoder #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
      .xclk           (xclk),
      .reset          (reset),
      .enable         (enable),
      .enc_a_in       (enc_a_in),
      .enc_b_in       (enc_b_in),
      .enc_i_in       (enc_i_in),
      .clear_count    (clear_count),
      .index_clear_en (index_clear_en),
      .error_clear    (error_clear),
      .position       (position),
      .index_position (index_position),
      .index_seen     (index_seen),
      .direction      (direction),
      .quad_error     (quad_error)
   );

   always #5 xclk = ~xclk;

   typedef struct packed {
      logic [CNT_W-1:0] pos;
      logic [CNT_W-1:0] ipos;
      logic             seen;
      logic             dir;
      logic             err;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model state. Raw samples are kept as a history with the newest
   // sample in bit 0. The filtered levels are also kept as a short history.
   bit [HW-1:0]      ra, rb, ri;
   bit [3:0]         fa, fb, fi;
   logic [CNT_W-1:0] m_pos, m_ipos;
   bit               m_seen, m_dir, m_err;
   int               cur_g;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns the position of an AB level in the forward cycle 00,01,11,10.
   function automatic int gidx(input bit a, input bit b);
      case ({a, b})
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gcode(input int g);
      case (g)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   // A filtered level flips once the synchronized input (raw delayed two
   // samples) has held the opposite level for FILT_LEN consecutive samples.
   function automatic bit filt_next(input bit [HW-1:0] h, input bit cur);
      bit all_diff = 1'b1;
      for (int k = 2; k <= FILT_LEN + 1; k++)
         if (h[k] == cur) all_diff = 1'b0;
      return all_diff ? ~cur : cur;
   endfunction

   // The model advances by one clock edge, using the inputs present now.
   task automatic model_edge();
      int               d;
      bit               rise;
      logic [CNT_W-1:0] nxt;
      if (reset) begin
         ra = '0; rb = '0; ri = '0; fa = '0; fb = '0; fi = '0;
         m_pos = '0; m_ipos = '0; m_seen = 0; m_dir = 0; m_err = 0;
      end else begin
         ra = {ra[HW-2:0], bit'(enc_a_in)};
         rb = {rb[HW-2:0], bit'(enc_b_in)};
         ri = {ri[HW-2:0], bit'(enc_i_in)};
         fa = {fa[2:0], filt_next(ra, fa[0])};
         fb = {fb[2:0], filt_next(rb, fb[0])};
         fi = {fi[2:0], filt_next(ri, fi[0])};
         // A filtered change reaches the count two edges after it appears.
         d    = (gidx(fa[2], fb[2]) - gidx(fa[3], fb[3]) + 4) % 4;
         rise = fi[2] & ~fi[3];
         nxt  = m_pos;
         if (clear_count)                          nxt = '0;
         else if (rise && index_clear_en && enable) nxt = '0;
         else if (enable && d == 1)                nxt = m_pos + 1'b1;
         else if (enable && d == 3)                nxt = m_pos - 1'b1;
         if (enable && d == 1) m_dir = 1;
         if (enable && d == 3) m_dir = 0;
         if (d == 2) m_err = 1;
         else if (error_clear) m_err = 0;
         if (rise) m_ipos = nxt;
         if (clear_count) m_seen = 0;
         else if (rise) m_seen = 1;
         m_pos = nxt;
      end
   endtask

   task automatic tick();
      exp_t e;
      model_edge();
      e.pos = m_pos; e.ipos = m_ipos; e.seen = m_seen; e.dir = m_dir; e.err = m_err;
      sb_q.push_back(e);
      @(negedge xclk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic drive_g(input int g);
      logic [1:0] c;
      c = gcode(g);
      enc_a_in = c[1];
      enc_b_in = c[0];
      cur_g    = g;
   endtask

   task automatic steps(input int n, input int dir, input int hold);
      repeat (n) begin
         drive_g((cur_g + dir + 4) % 4);
         idle(hold);
      end
   endtask

   // Monitor: pops one expectation per clock edge and compares it.
   initial begin
      exp_t e;
      forever begin
         @(posedge xclk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp("sb_position",       position,       e.pos);
            cmp("sb_index_position", index_position, e.ipos);
            cmp("sb_index_seen",     index_seen,     e.seen);
            cmp("sb_direction",      direction,      e.dir);
            cmp("sb_quad_error",     quad_error,     e.err);
         end
      end
   end

   initial begin
      int r;
      reset = 1; enable = 0; enc_a_in = 0; enc_b_in = 0; enc_i_in = 0;
      clear_count = 0; index_clear_en = 0; error_clear = 0; cur_g = 0;
      idle(3);
      cmp("rst_position", position, 0);
      cmp("rst_index_position", index_position, 0);
      cmp("rst_flags", {index_seen, direction, quad_error}, 0);
      reset = 0; enable = 1;
      idle(2);

      // Forward counting, with an exact check of the first-step latency.
      drive_g(1);
      idle(7);
      cmp("latency_before", position, 0);
      idle(1);
      cmp("latency_at", position, 1);
      idle(2);
      steps(31, 1, 10);
      idle(8);
      cmp("fwd_position", position, 32);
      cmp("fwd_direction", direction, 1);
      cmp("fwd_quad_error", quad_error, 0);

      // Reverse steps that wrap below zero, then forward steps back to zero.
      clear_count = 1; idle(1); clear_count = 0; idle(1);
      cmp("clear_count", position, 0);
      steps(3, -1, 10); idle(8);
      cmp("rev_wrap_position", position, 16'hFFFD);
      cmp("rev_direction", direction, 0);
      steps(3, 1, 10); idle(8);
      cmp("fwd_wrap_position", position, 16'h0000);

      // Glitch rejection on A. B is high, so a valid A rise is a +1 step.
      steps(1, 1, 10);
      clear_count = 1; idle(1); clear_count = 0; idle(8);
      enc_a_in = 1; idle(3); enc_a_in = 0; idle(12);
      cmp("glitch_reject", position, 0);
      drive_g(2); idle(4); idle(10);
      cmp("glitch_accept", position, 1);

      // Illegal transitions.
      drive_g(0); idle(12);
      cmp("illegal_err", quad_error, 1);
      cmp("illegal_pos", position, 1);
      error_clear = 1; idle(1); error_clear = 0; idle(1);
      cmp("err_cleared", quad_error, 0);
      drive_g(2); idle(7);
      error_clear = 1; idle(1); error_clear = 0; idle(2);
      cmp("err_set_wins", quad_error, 1);
      error_clear = 1; idle(1); error_clear = 0; idle(1);
      cmp("err_cleared2", quad_error, 0);

      // Index capture, index zeroing, and clear_count in the same cycle as an
      // Index rise.
      clear_count = 1; idle(1); clear_count = 0;
      steps(100, 1, 6); idle(8);
      cmp("pos_100", position, 100);
      enc_i_in = 1; idle(10);
      cmp("index_pos_100", index_position, 100);
      cmp("index_seen_set", index_seen, 1);
      steps(3, 1, 6); idle(8);
      cmp("count_after_index", position, 103);
      enc_i_in = 0; idle(8);
      index_clear_en = 1; enc_i_in = 1; idle(10);
      cmp("index_zeroes_pos", position, 0);
      cmp("index_pos_zero", index_position, 0);
      enc_i_in = 0; index_clear_en = 0; idle(8);
      steps(5, 1, 6); idle(8);
      enc_i_in = 1; idle(7);
      clear_count = 1; idle(1); clear_count = 0; idle(2);
      cmp("clr_with_index_pos", position, 0);
      cmp("clr_with_index_seen", index_seen, 0);
      enc_i_in = 0; idle(8);

      // Enable freeze, re-enable with no step, and reset in the middle of a
      // step.
      enable = 0; steps(5, 1, 10); idle(8);
      cmp("en_frozen", position, 0);
      enable = 1; idle(20);
      cmp("reenable_nostep", position, 0);
      steps(2, 1, 10); idle(8);
      cmp("reenable_count", position, 2);
      steps(1, 1, 3);
      reset = 1; idle(1);
      cmp("reset_mid_pos", position, 0);
      cmp("reset_mid_flags", {index_seen, direction, quad_error}, 0);
      reset = 0; idle(12);
      error_clear = 1; idle(1); error_clear = 0; idle(2);

      // Randomized traffic, including short pulses and illegal moves.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            r = $urandom_range(0, 9);
            if (r < 5)      drive_g((cur_g + 1) % 4);
            else if (r < 9) drive_g((cur_g + 3) % 4);
            else            drive_g((cur_g + 2) % 4);
         end
         if ($urandom_range(0, 19) == 0) enc_i_in = ~enc_i_in;
         enable         = ($urandom_range(0, 9) != 0);
         clear_count    = ($urandom_range(0, 49) == 0);
         index_clear_en = 1'($urandom_range(0, 1));
         error_clear    = ($urandom_range(0, 29) == 0);
         reset          = ($urandom_range(0, 399) == 0);
         tick();
      end
      reset = 0; clear_count = 0; error_clear = 0; enable = 1;
      idle(10);

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
